// File: rtl/prbs_checker_if.sv
// Receive-side bus for prbs_checker: serial beat input plus lock/error status.
interface prbs_checker_if #(
  parameter int unsigned ERR_W = 16
);
  logic             clear_i;
  logic             valid_i;
  logic             data_i;
  logic             locked_o;
  logic             err_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic [ERR_W-1:0] bit_cnt_o;

  modport master (
    output clear_i, valid_i, data_i,
    input  locked_o, err_o, err_cnt_o, bit_cnt_o
  );

  modport slave (
    input  clear_i, valid_i, data_i,
    output locked_o, err_o, err_cnt_o, bit_cnt_o
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising serial checker for the 4-bit PRBS generator (p = s[1]^s[3]).
// Optional beat counter enabled by defining PRBS_CHECKER_BITCNT_EN.
module prbs_checker #(
  parameter int unsigned LOCK_CNT    = 8,
  parameter int unsigned UNLOCK_ERRS = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic           clk,
  input  logic           reset,
  prbs_checker_if.slave  bus
);

  localparam int unsigned RUN_W  = 8;
  localparam int unsigned FILL_W = 3;
  localparam logic [FILL_W-1:0] FILL_LEN = FILL_W'(4);
  localparam logic [ERR_W-1:0]  CNT_MAX  = {ERR_W{1'b1}};

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [3:0]        s_q, s_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [RUN_W-1:0]  match_q, match_d;
  logic [RUN_W-1:0]  bad_q, bad_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              pred;
  logic              bit_beat;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == CNT_MAX) ? v : v + ERR_W'(1);
  endfunction

  assign pred     = s_q[1] ^ s_q[3];
  assign bit_beat = bus.valid_i && (state_q == LOCKED);

  // Search/lock state machine: next-state and counters
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    fill_d    = fill_q;
    match_d   = match_q;
    bad_d     = bad_q;
    err_d     = 1'b0;
    err_cnt_d = bus.clear_i ? '0 : err_cnt_q;

    if (bus.valid_i) begin
      unique case (state_q)
        SEARCH: begin
          s_d = {s_q[2:0], bus.data_i};
          if (fill_q != FILL_LEN) begin
            fill_d = fill_q + FILL_W'(1);
          end else if ((bus.data_i == pred) && (s_q != 4'd0)) begin
            if ((match_q + RUN_W'(1)) == RUN_W'(LOCK_CNT)) begin
              state_d = LOCKED;
              match_d = '0;
            end else begin
              match_d = match_q + RUN_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          s_d = {s_q[2:0], pred};
          if (bus.data_i != pred) begin
            err_d     = 1'b1;
            err_cnt_d = sat_inc(err_cnt_d);
            if ((bad_q + RUN_W'(1)) == RUN_W'(UNLOCK_ERRS)) begin
              state_d = SEARCH;
              fill_d  = '0;
              match_d = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + RUN_W'(1);
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      s_q       <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      bad_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      bad_q     <= bad_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef PRBS_CHECKER_BITCNT_EN
  logic [ERR_W-1:0] bit_cnt_q, bit_cnt_d;

  // Beats checked while locked; clear applies before the increment
  always_comb begin
    bit_cnt_d = bus.clear_i ? '0 : bit_cnt_q;
    if (bit_beat) bit_cnt_d = sat_inc(bit_cnt_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bit_cnt_q <= '0;
    else       bit_cnt_q <= bit_cnt_d;
  end

  assign bus.bit_cnt_o = bit_cnt_q;
`else
  logic unused_bit_beat;
  assign unused_bit_beat = bit_beat;
  assign bus.bit_cnt_o   = '0;
`endif

  assign bus.locked_o  = (state_q == LOCKED);
  assign bus.err_o     = err_q;
  assign bus.err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: driver pushes model expectations, monitor compares each cycle.
module tb_prbs_checker;
  localparam int unsigned LOCK_CNT    = 8;
  localparam int unsigned UNLOCK_ERRS = 4;
  localparam int unsigned ERR_W       = 4;
  localparam int          CMAX        = (1 << ERR_W) - 1;
`ifdef PRBS_CHECKER_BITCNT_EN
  localparam bit BITCNT_EN = 1'b1;
`else
  localparam bit BITCNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prbs_checker_if #(.ERR_W(ERR_W)) bus ();

  prbs_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERRS(UNLOCK_ERRS), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit locked;
    bit err;
    int ec;
    int bc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: bit history plus integer counters
  bit   hist[$];
  bit   m_locked;
  int   m_fill, m_match, m_bad, m_ec, m_bc;
  bit   m_err;
  bit [3:0] g;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic bit gen_next();
    g = {g[2:0], g[1] ^ g[3]};
    return g[0];
  endfunction

  function automatic void model_reset();
    hist = '{0, 0, 0, 0};
    m_locked = 0; m_fill = 0; m_match = 0; m_bad = 0;
    m_ec = 0; m_bc = 0; m_err = 0;
    g = 4'hE;
  endfunction

  function automatic void model_beat(input bit v, input bit d, input bit clr);
    int  n;
    bit  pred, nz, ev_err, ev_bit;
    ev_err = 0; ev_bit = 0; m_err = 0;
    if (v) begin
      n    = hist.size();
      pred = hist[n-2] ^ hist[n-4];
      nz   = hist[n-1] | hist[n-2] | hist[n-3] | hist[n-4];
      if (!m_locked) begin
        hist.push_back(d);
        if (m_fill < 4) m_fill++;
        else if (d == pred && nz) begin
          m_match++;
          if (m_match == LOCK_CNT) begin m_locked = 1; m_match = 0; end
        end else m_match = 0;
      end else begin
        hist.push_back(pred);
        ev_bit = 1;
        if (d != pred) begin
          ev_err = 1; m_err = 1; m_bad++;
          if (m_bad == UNLOCK_ERRS) begin
            m_locked = 0; m_fill = 0; m_match = 0; m_bad = 0;
          end
        end else m_bad = 0;
      end
      if (hist.size() > 8) void'(hist.pop_front());
    end
    if (clr) begin m_ec = 0; m_bc = 0; end
    if (ev_err && m_ec < CMAX) m_ec++;
    if (ev_bit && BITCNT_EN && m_bc < CMAX) m_bc++;
  endfunction

  task automatic step_d(input bit v, input bit d, input bit clr);
    exp_t e;
    @(negedge clk);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.clear_i = clr;
    model_beat(v, d, clr);
    e.locked = m_locked; e.err = m_err; e.ec = m_ec; e.bc = m_bc;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit v, input bit flip, input bit clr);
    bit d;
    if (v) d = gen_next() ^ flip;
    else   d = 1'($urandom_range(0, 1));
    step_d(v, d, clr);
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_locked",  int'(bus.locked_o), 0);
    chk("rst_err",     int'(bus.err_o), 0);
    chk("rst_err_cnt", int'(bus.err_cnt_o), 0);
    chk("rst_bit_cnt", int'(bus.bit_cnt_o), 0);
    model_reset();
    bus.valid_i = 1'b0;
    bus.clear_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic lock_seq(input string tag);
    for (int i = 0; i < 11; i++) step(1, 0, 0);
    sample();
    chk({tag, "_prelock"}, int'(bus.locked_o), 0);
    step(1, 0, 0);
    sample();
    chk({tag, "_lock12"}, int'(bus.locked_o), 1);
  endtask

  // Monitor: compare every clocked output against the queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.locked_o !== e.locked || bus.err_o !== e.err ||
          int'(bus.err_cnt_o) != e.ec || int'(bus.bit_cnt_o) != e.bc) begin
        errors++;
        $display("FAIL scoreboard: got locked=%0d err=%0d ec=%0d bc=%0d expected locked=%0d err=%0d ec=%0d bc=%0d at %0t",
                 bus.locked_o, bus.err_o, bus.err_cnt_o, bus.bit_cnt_o,
                 e.locked, e.err, e.ec, e.bc, $time);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = 1'b0;
    bus.clear_i = 1'b0;
    model_reset();
    do_reset();

    // Lock from seed 0xE stream, then beat counting
    lock_seq("lock");
    chk("lock_err_cnt", int'(bus.err_cnt_o), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    sample();
    chk("bit_cnt_run", int'(bus.bit_cnt_o), BITCNT_EN ? 3 : 0);

    // Single error: one pulse, no multiplication
    step(1, 1, 0);
    sample();
    chk("single_err_o", int'(bus.err_o), 1);
    chk("single_err_cnt", int'(bus.err_cnt_o), 1);
    chk("single_locked", int'(bus.locked_o), 1);
    step(1, 0, 0);
    sample();
    chk("single_err_clear", int'(bus.err_o), 0);
    chk("single_err_cnt_hold", int'(bus.err_cnt_o), 1);

    // Four consecutive errors unlock; clean stream relocks after 12 beats
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    sample();
    chk("unlock_held3", int'(bus.locked_o), 1);
    step(1, 1, 0);
    sample();
    chk("unlock_locked", int'(bus.locked_o), 0);
    chk("unlock_err_o", int'(bus.err_o), 1);
    chk("unlock_err_cnt", int'(bus.err_cnt_o), 5);
    lock_seq("relock");

    // All-zero stream never locks
    do_reset();
    for (int i = 0; i < 100; i++) step_d(1, 0, 0);
    sample();
    chk("zero_stream", int'(bus.locked_o), 0);

    // Alternating valid: 12 valid beats to lock
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    sample();
    chk("gap_prelock", int'(bus.locked_o), 0);
    step(1, 0, 0);
    sample();
    chk("gap_lock", int'(bus.locked_o), 1);

    // Saturation and clear priority
    do_reset();
    lock_seq("sat");
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0);
      step(1, 0, 0);
    end
    sample();
    chk("sat_err_cnt", int'(bus.err_cnt_o), CMAX);
    chk("sat_locked", int'(bus.locked_o), 1);
    step(1, 1, 1);
    sample();
    chk("clear_with_err", int'(bus.err_cnt_o), 1);
    step_d(0, 0, 1);
    sample();
    chk("clear_alone", int'(bus.err_cnt_o), 0);

    // Reset mid-lock, immediately after an error beat
    step(1, 1, 0);
    do_reset();
    lock_seq("rst_relock");

    // Randomized traffic: gaps, error bursts, zero runs, clears
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        for (int k = 0; k < 5; k++) step(1, 1, 0);
      end else if (r < 3) begin
        for (int k = 0; k < 20; k++) step_d(1, 0, 0);
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 39) == 0);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
